// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory block copier: default widths and the
// copy FSM state encoding. The optional running checksum is enabled by
// defining the CHECKSUM_EN macro.
package mem_copy_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Address generator for the block copier: holds the source/destination base
// addresses, the copy length and the running word index. Produces the
// current source and destination addresses (wrapping modulo 2**ADDR_W) and a
// flag marking the final word of the copy.
module mem_copy_addr_gen #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 13
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_src_addr,
    output logic [ADDR_W-1:0] o_dst_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_index;

    // Latch the copy parameters on an accepted start; step the index after each write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_index <= '0;
        end else if (i_load) begin
            r_src   <= i_src;
            r_dst   <= i_dst;
            r_len   <= i_len;
            r_index <= '0;
        end else if (i_inc) begin
            r_index <= r_index + LEN_W'(1);
        end
    end

    // Only the low ADDR_W index bits matter for the address: the sum wraps naturally.
    assign o_src_addr = r_src + r_index[ADDR_W-1:0];
    assign o_dst_addr = r_dst + r_index[ADDR_W-1:0];
    assign o_last     = (r_index == (r_len - LEN_W'(1)));

endmodule

// File: rtl/mem_block_copier.sv
// Simple DMA engine: copies LENGTH words from SRC to DST in the data memory,
// one read cycle followed by one write cycle per word, strictly ascending.
// Optional feature: define CHECKSUM_EN to add a modulo-2**DATA_W sum of the
// copied words on the checksum output.
module mem_block_copier
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_buf;
    logic              w_accept;
    logic [ADDR_W-1:0] w_src_cur;
    logic [ADDR_W-1:0] w_dst_cur;
    logic              w_last;

    assign w_accept = (r_state == IDLE) && start;

    mem_copy_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_src      (src_addr),
        .i_dst      (dst_addr),
        .i_len      (length),
        .i_inc      (r_state == WRITE),
        .o_src_addr (w_src_cur),
        .o_dst_addr (w_dst_cur),
        .o_last     (w_last)
    );

    // State register; reset abandons any copy in flight immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a zero-length request skips straight to FIN.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = (length == '0) ? FIN : READ;
            READ:    w_state_next = WRITE;
            WRITE:   w_state_next = w_last ? FIN : READ;
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs decode from the state alone, so reset clears them without waiting for a clock.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = '0;
        write_data = '0;
        unique case (r_state)
            IDLE: ;
            READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                addr     = w_src_cur;
            end
            WRITE: begin
                busy       = 1'b1;
                mem_write  = 1'b1;
                addr       = w_dst_cur;
                write_data = r_buf;
            end
            FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture the word read from memory so it can be written back next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '0;
        end else if (r_state == READ) begin
            r_buf <= read_data;
        end
    end

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Running sum of copied words; cleared on start, held after done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (r_state == READ) begin
            r_checksum <= r_checksum + read_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_mem_block_copier.sv
// Self-checking bench for mem_block_copier with a 4K x 16 memory model.
// Define CHECKSUM_EN to also exercise the checksum output.
module tb_mem_block_copier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] src_addr = '0;
    logic [11:0] dst_addr = '0;
    logic [12:0] length = '0;
    logic        busy, done, mem_read, mem_write;
    logic [11:0] addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
`ifdef CHECKSUM_EN
    logic [15:0] checksum;
`endif

    always #5 clk = ~clk;

    mem_block_copier dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
`ifdef CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // Memory model: combinational read, write on posedge; bench preload port shares the write path.
    logic [15:0] mem [0:4095];
    logic        tb_we = 1'b0;
    logic [11:0] tb_waddr = '0;
    logic [15:0] tb_wdata = '0;
    logic [11:0] rd_addr [0:63];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic        overlap_seen = 1'b0;
    logic        idle_strobe_seen = 1'b0;

    assign read_data = mem[addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) begin
            mem[addr] <= write_data;
            wr_cnt    <= wr_cnt + 1;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end
        if (mem_read) begin
            rd_addr[rd_cnt % 64] <= addr;
            rd_cnt               <= rd_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (mem_read && mem_write) overlap_seen <= 1'b1;
        if ((!busy || done) && (mem_read || mem_write)) idle_strobe_seen <= 1'b1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat(input logic [11:0] a);
        return {4'hA, a} ^ 16'h0F0F;
    endfunction

    task automatic load_word(input logic [11:0] a, input logic [15:0] v);
        @(negedge clk);
        tb_waddr = a;
        tb_wdata = v;
        tb_we    = 1'b1;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Drive a start pulse; returns the cycle count captured just after the sampling edge.
    task automatic pulse_start(input logic [11:0] s, input logic [11:0] d, input logic [12:0] n,
                               output int cyc_e0);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc_e0 = cyc;
    endtask

    // Wait (bounded) for done; latency counts edges from the start-sampling edge.
    task automatic wait_done(input int cyc_e0, output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - cyc_e0 + 1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [11:0] src;
        logic [11:0] dst;
        logic [12:0] len;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int          e0, lat, rd0, wr0, dn0;
        logic [11:0] a;
        logic [15:0] sum;

        vecs[0] = '{src: 12'h010, dst: 12'h100, len: 13'd4, exp_lat: 9};
        vecs[1] = '{src: 12'h050, dst: 12'h150, len: 13'd0, exp_lat: 1};
        vecs[2] = '{src: 12'hFFE, dst: 12'h200, len: 13'd4, exp_lat: 9};
        vecs[3] = '{src: 12'h020, dst: 12'h300, len: 13'd1, exp_lat: 3};
        vecs[4] = '{src: 12'h7F0, dst: 12'hFFD, len: 13'd5, exp_lat: 11};

        // Reset state
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("reset_addr_wdata", 32'({addr, write_data}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven copies
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                a = vecs[v].src + 12'(i);
                load_word(a, pat(a));
            end
            for (int i = 0; i <= int'(vecs[v].len); i++) begin
                a = vecs[v].dst + 12'(i);
                load_word(a, 16'hDEAD);
            end
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            pulse_start(vecs[v].src, vecs[v].dst, vecs[v].len, e0);
            wait_done(e0, lat);
            $display("copy %0d src=%03h dst=%03h len=%0d latency=%0d", v, vecs[v].src, vecs[v].dst,
                     vecs[v].len, lat);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
`ifdef CHECKSUM_EN
            sum = '0;
            for (int i = 0; i < int'(vecs[v].len); i++) sum = sum + pat(vecs[v].src + 12'(i));
            check($sformatf("v%0d_checksum", v), 32'(checksum), 32'(sum));
`endif
            @(negedge clk);
            check($sformatf("v%0d_busy_after", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_reads", v), 32'(rd_cnt - rd0), 32'(vecs[v].len));
            check($sformatf("v%0d_writes", v), 32'(wr_cnt - wr0), 32'(vecs[v].len));
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                a = vecs[v].src + 12'(i);
                check($sformatf("v%0d_rd_addr%0d", v, i), 32'(rd_addr[(rd0 + i) % 64]), 32'(a));
                check($sformatf("v%0d_dst%0d", v, i), 32'(mem[vecs[v].dst + 12'(i)]), 32'(pat(a)));
            end
            a = vecs[v].dst + 12'(vecs[v].len);
            check($sformatf("v%0d_dst_beyond", v), 32'(mem[a]), 32'h0000DEAD);
        end

        // Asynchronous reset during the third write of an 8-word copy
        for (int i = 0; i < 8; i++) begin
            load_word(12'h400 + 12'(i), pat(12'h400 + 12'(i)));
            load_word(12'h500 + 12'(i), 16'hDEAD);
        end
        wr0 = wr_cnt;
        pulse_start(12'h400, 12'h500, 13'd8, e0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_pre_write3", 32'({mem_write, addr}), 32'({1'b1, 12'h502}));
        #1 rst = 1'b0;
        #1;
        $display("async reset asserted mid-copy at t=%0t", $time);
        check("rst_async_busy_done", 32'({busy, done}), 32'd0);
        check("rst_async_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("rst_async_addr_wdata", 32'({addr, write_data}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_writes", 32'(wr_cnt - wr0), 32'd2);
        for (int i = 0; i < 8; i++) begin
            a = 12'h500 + 12'(i);
            check($sformatf("rst_dst%0d", i), 32'(mem[a]),
                  (i < 2) ? 32'(pat(12'h400 + 12'(i))) : 32'h0000DEAD);
        end

        // Start pulsed again while busy must be ignored
        for (int i = 0; i < 3; i++) begin
            load_word(12'h600 + 12'(i), pat(12'h600 + 12'(i)));
            load_word(12'h680 + 12'(i), 16'hDEAD);
            load_word(12'h780 + 12'(i), 16'hBEEF);
        end
        dn0 = done_cnt;
        pulse_start(12'h600, 12'h680, 13'd3, e0);
        @(negedge clk);
        src_addr = 12'h700;
        dst_addr = 12'h780;
        length   = 13'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(e0, lat);
        $display("busy-restart copy latency=%0d", lat);
        check("restart_latency", 32'(lat), 32'd7);
        repeat (12) @(negedge clk);
        check("restart_done_pulses", 32'(done_cnt - dn0), 32'd1);
        check("restart_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("restart_dst%0d", i), 32'(mem[12'h680 + 12'(i)]),
                  32'(pat(12'h600 + 12'(i))));
            check($sformatf("restart_other%0d", i), 32'(mem[12'h780 + 12'(i)]), 32'h0000BEEF);
        end

`ifdef CHECKSUM_EN
        // Checksum wraps modulo 2**16
        load_word(12'h800, 16'hFFFF);
        load_word(12'h801, 16'h0002);
        pulse_start(12'h800, 12'h880, 13'd2, e0);
        wait_done(e0, lat);
        $display("checksum copy latency=%0d checksum=%04h", lat, checksum);
        check("cks_latency", 32'(lat), 32'd5);
        check("cks_value", 32'(checksum), 32'h0001);
        repeat (3) @(negedge clk);
        check("cks_hold", 32'(checksum), 32'h0001);
`endif

        check("strobe_overlap", 32'(overlap_seen), 32'd0);
        check("strobe_idle_fin", 32'(idle_strobe_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
